// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add_arbiter
// Purpose  : Round-robin sequencer sharing one registered adder among NREQ
//            requesters, returning tagged sums on a single response channel.
// Revision : 1.0
// ============================================================================
module add_arbiter #(
   parameter  int WIDTH       = 8,
   parameter  int NREQ        = 4,
   parameter  int ADD_LATENCY = 1,
   localparam int IDW         = $clog2(NREQ)
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_in0,
   input  logic [NREQ*WIDTH-1:0] req_in1,
   output logic [WIDTH-1:0]      add_in0,
   output logic [WIDTH-1:0]      add_in1,
   input  logic [WIDTH-1:0]      add_out,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [IDW-1:0]        resp_id,
   output logic [WIDTH-1:0]      resp_sum,
   output logic                  busy
);

   localparam int c_CW = $clog2(ADD_LATENCY + 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_ISSUE = 2'd1;
   localparam logic [1:0] c_RESP  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic [IDW-1:0]   r_last;
   logic [IDW-1:0]   r_resp_id;
   logic [IDW-1:0]   w_gidx;
   logic [IDW-1:0]   w_cand;
   logic             w_any;
   logic [NREQ-1:0]  w_grant;
   logic [c_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_op0;
   logic [WIDTH-1:0] r_op1;
   logic [WIDTH-1:0] r_sum;
   logic             w_done;
   int               w_idx;

   // Search starts just after the last winner so every requester gets a turn.
   always_comb begin
      w_any  = 1'b0;
      w_gidx = '0;
      w_idx  = 0;
      w_cand = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_idx  = (int'(r_last) + k) % NREQ;
         w_cand = IDW'(w_idx);
         if (!w_any && req_valid[w_cand]) begin
            w_any  = 1'b1;
            w_gidx = w_cand;
         end
      end
   end

   always_comb begin
      w_grant = '0;
      if (w_any)
         w_grant[w_gidx] = 1'b1;
   end

   assign w_done = (r_cnt == c_CW'(ADD_LATENCY));

   always_ff @(posedge clock) begin
      if (reset)
         r_state <= c_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE:  if (w_any)      w_next = c_ISSUE;
         c_ISSUE: if (w_done)     w_next = c_RESP;
         c_RESP:  if (resp_ready) w_next = c_IDLE;
         default:                 w_next = c_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (r_state == c_IDLE && !reset) ? w_grant : '0;
      resp_valid = (r_state == c_RESP);
      busy       = (r_state != c_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_op0     <= '0;
         r_op1     <= '0;
         r_sum     <= '0;
         r_resp_id <= '0;
         r_last    <= IDW'(NREQ - 1);
         r_cnt     <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any) begin
                  r_op0     <= req_in0[w_gidx*WIDTH +: WIDTH];
                  r_op1     <= req_in1[w_gidx*WIDTH +: WIDTH];
                  r_resp_id <= w_gidx;
                  r_last    <= w_gidx;
                  r_cnt     <= '0;
               end
            end
            c_ISSUE: begin
               r_cnt <= r_cnt + c_CW'(1);
               if (w_done)
                  r_sum <= add_out;
            end
            default: ;
         endcase
      end
   end

   // Operands live in registers, so the adder inputs stay glitch-free.
   assign add_in0  = r_op0;
   assign add_in1  = r_op1;
   assign resp_id  = r_resp_id;
   assign resp_sum = r_sum;

endmodule
`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_arbiter
// Purpose  : Self-checking bench for add_arbiter against a transaction model.
// Revision : 1.0
// ============================================================================
module tb_add_arbiter;

   localparam int W    = 8;
   localparam int NREQ = 4;
   localparam int IDW  = 2;
   localparam int L1   = 1;
   localparam int L3   = 3;

   logic              clk;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ*W-1:0] req_in0;
   logic [NREQ*W-1:0] req_in1;
   logic              resp_ready;

   logic [NREQ-1:0]   req_ready,  rdy3;
   logic [W-1:0]      add_in0,    add_in1, a3_0, a3_1;
   logic [W-1:0]      add_out,    add_out3;
   logic              resp_valid, rv3;
   logic [IDW-1:0]    resp_id,    id3;
   logic [W-1:0]      resp_sum,   sum3;
   logic              busy,       busy3;
   logic [W-1:0]      p3 [0:2];

   add_arbiter #(.WIDTH(W), .NREQ(NREQ), .ADD_LATENCY(L1)) u_dut (
      .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_in0(req_in0), .req_in1(req_in1), .add_in0(add_in0), .add_in1(add_in1),
      .add_out(add_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_sum(resp_sum), .busy(busy));

   add_arbiter #(.WIDTH(W), .NREQ(NREQ), .ADD_LATENCY(L3)) u_dut3 (
      .clock(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
      .req_in0(req_in0), .req_in1(req_in1), .add_in0(a3_0), .add_in1(a3_1),
      .add_out(add_out3), .resp_valid(rv3), .resp_ready(resp_ready),
      .resp_id(id3), .resp_sum(sum3), .busy(busy3));

   // Behavioural registered adders with latency 1 and 3.
   always @(posedge clk) begin
      add_out <= add_in0 + add_in1;
      p3[0]   <= a3_0 + a3_1;
      p3[1]   <= p3[0];
      p3[2]   <= p3[1];
   end
   assign add_out3 = p3[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Transaction-level reference state.
   int cyc = 0;
   bit m_busy;
   int m_resp_at, m_last, m_rid, m_rsum, m_sum, m_op0, m_op1;
   int q_grant[$];
   int q_gcyc[$];
   logic [NREQ-1:0] s_ready;
   logic            s_rv, s_rv3;
   logic [IDW-1:0]  s_id;
   logic [W-1:0]    s_sum, s_sum3;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++)
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [NREQ*W-1:0] lane(input int i, input logic [W-1:0] v);
      logic [NREQ*W-1:0] r;
      r = '0;
      r[i*W +: W] = v;
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_last = NREQ - 1; m_rid = 0; m_rsum = 0;
      m_op0 = 0; m_op1 = 0; m_resp_at = 0; m_sum = 0;
   endtask

   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                       input logic [NREQ*W-1:0] b, input logic rr, input logic rs);
      int g;
      logic [NREQ-1:0] exp_ready;
      req_valid = v; req_in0 = a; req_in1 = b; resp_ready = rr; reset = rs;
      @(negedge clk);
      g = (!rs && !m_busy) ? rr_pick(v, m_last) : -1;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready",  req_ready, exp_ready);
      check("busy",       busy, m_busy);
      check("resp_valid", resp_valid, (m_busy && cyc >= m_resp_at));
      check("resp_id",    resp_id, m_rid);
      check("resp_sum",   resp_sum, m_rsum);
      check("add_in0",    add_in0, m_op0);
      check("add_in1",    add_in1, m_op1);
      s_ready = req_ready; s_rv = resp_valid; s_id = resp_id; s_sum = resp_sum;
      s_rv3 = rv3; s_sum3 = sum3;
      if (g >= 0) begin
         q_grant.push_back(g);
         q_gcyc.push_back(cyc);
      end
      if (rs) begin
         model_reset();
      end else if (!m_busy) begin
         if (g >= 0) begin
            m_busy    = 1;
            m_resp_at = cyc + L1 + 2;
            m_rid     = g;
            m_last    = g;
            m_op0     = int'(a[g*W +: W]);
            m_op1     = int'(b[g*W +: W]);
            m_sum     = (m_op0 + m_op1) % 256;
         end
      end else begin
         if (cyc == m_resp_at - 1) m_rsum = m_sum;
         if (cyc >= m_resp_at && rr) m_busy = 0;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step('0, '0, '0, 1'b1, 1'b1);
      step('0, '0, '0, 1'b1, 1'b1);
      q_grant.delete();
      q_gcyc.delete();
   endtask

   initial begin
      int rr_exp[5] = '{0, 1, 2, 3, 0};
      int c0;
      req_valid = '0; req_in0 = '0; req_in1 = '0; resp_ready = 1'b1; reset = 1'b1;
      model_reset();
      do_reset();

      // Single request from requester 2.
      step(4'b0100, lane(2, 8'h05), lane(2, 8'h03), 1'b1, 1'b0);
      check("single_grant", s_ready, 4'b0100);
      for (int c = 1; c <= 3; c++) begin
         step('0, '0, '0, 1'b1, 1'b0);
         check("single_rv", s_rv, (c == 3));
      end
      check("single_id",  s_id, 2);
      check("single_sum", s_sum, 8'h08);

      // Overflow drops the carry.
      do_reset();
      step(4'b0001, lane(0, 8'hFF), lane(0, 8'h02), 1'b1, 1'b0);
      for (int c = 1; c <= 3; c++) step('0, '0, '0, 1'b1, 1'b0);
      check("ovf_rv",  s_rv, 1'b1);
      check("ovf_sum", s_sum, 8'h01);

      // Round-robin with everyone requesting.
      do_reset();
      for (int c = 0; c < 20; c++)
         step(4'b1111, {$urandom, $urandom} , {$urandom, $urandom}, 1'b1, 1'b0);
      check("rr_count", (q_grant.size() >= 5), 1'b1);
      for (int i = 0; i < 5; i++)
         if (i < q_grant.size()) check("rr_order", q_grant[i], rr_exp[i]);
      for (int i = 1; i < 5; i++)
         if (i < q_gcyc.size()) check("rr_spacing", q_gcyc[i] - q_gcyc[i-1], 4);

      // Response backpressure.
      do_reset();
      step(4'b0001, lane(0, 8'h21), lane(0, 8'h12), 1'b0, 1'b0);
      c0 = q_gcyc[0];
      for (int c = 1; c <= 8; c++) step(4'b1111, '1, '1, 1'b0, 1'b0);
      check("bp_held_rv",  s_rv, 1'b1);
      check("bp_held_sum", s_sum, 8'h33);
      check("bp_no_grant", q_grant.size(), 1);
      step(4'b1111, '1, '1, 1'b1, 1'b0);
      step(4'b1111, '1, '1, 1'b1, 1'b0);
      check("bp_regrant", q_grant.size(), 2);
      if (q_gcyc.size() == 2) check("bp_regrant_cyc", q_gcyc[1] - c0, 10);

      // Reset during ISSUE aborts the operation.
      do_reset();
      step(4'b0010, lane(1, 8'h44), lane(1, 8'h11), 1'b1, 1'b0);
      step('0, '0, '0, 1'b1, 1'b0);
      step('0, '0, '0, 1'b1, 1'b1);
      q_grant.delete();
      step(4'b1111, '1, '1, 1'b1, 1'b0);
      check("rst_rv", s_rv, 1'b0);
      check("rst_grant0", (q_grant.size() == 1 && q_grant[0] == 0), 1'b1);
      for (int c = 0; c < 4; c++) step('0, '0, '0, 1'b1, 1'b0);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 800; c++)
         step(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));

      // ADD_LATENCY = 3 instance.
      do_reset();
      step(4'b0001, lane(0, 8'h10), lane(0, 8'h20), 1'b1, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         step('0, '0, '0, 1'b1, 1'b0);
         check("l3_rv", s_rv3, (c == 5));
         if (c == 5) check("l3_sum", s_sum3, 8'h30);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
